// File: rtl/operand_pipe_pkg.sv
// Shared helpers for the operand register pipeline: a width-generic byte merge.
// Every operand pipe instance, whatever its width, uses this one merge routine.
package operand_pipe_pkg;

    virtual class operand_merge #(parameter int DATA_WIDTH = 32);
        localparam int NUM_BYTES = DATA_WIDTH / 8;

        // Bytes whose enable is set come from new_val, the rest keep old_val.
        static function logic [DATA_WIDTH-1:0] byte_merge(
            input logic [DATA_WIDTH-1:0] old_val,
            input logic [DATA_WIDTH-1:0] new_val,
            input logic [NUM_BYTES-1:0]  be
        );
            logic [DATA_WIDTH-1:0] merged;
            merged = old_val;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    merged[8*i +: 8] = new_val[8*i +: 8];
                end
            end
            return merged;
        endfunction
    endclass

endpackage

// File: rtl/operand_reg_pipe_if.sv
// Load/control and result bundle between operand-load decode and one operand pipe.
interface operand_reg_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      load_en;
    logic [DATA_WIDTH/8-1:0]   load_be;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      stall;
    logic                      flush;
    logic [DATA_WIDTH-1:0]     hold_out;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      out_valid;
    logic                      out_fresh;

    modport master (
        output load_en, load_be, data_in, stall, flush,
        input  hold_out, data_out, out_valid, out_fresh
    );

    modport slave (
        input  load_en, load_be, data_in, stall, flush,
        output hold_out, data_out, out_valid, out_fresh
    );
endinterface

// File: rtl/operand_pipe_stage.sv
// One delay-line stage holding {data, valid, fresh}; clear beats enable.
module operand_pipe_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  fresh_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fresh_out
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fresh_q, fresh_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fresh_d = fresh_q;
        if (clr) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
            fresh_d = 1'b0;
        end else if (en) begin
            data_d  = data_in;
            valid_d = valid_in;
            fresh_d = fresh_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fresh_q <= fresh_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign fresh_out = fresh_q;

endmodule

// File: rtl/operand_reg_pipe.sv
// Operand hold register with byte-masked load feeding a DEPTH-stage delay line
// that carries valid and load-freshness tags alongside the data.
module operand_reg_pipe
    import operand_pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    operand_reg_pipe_if.slave  bus
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("operand_reg_pipe: DEPTH must be at least 1");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("operand_reg_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end

    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  loaded_q, loaded_d;
    logic                  load_ok;
    logic                  stage_en;

    logic [DATA_WIDTH-1:0] stage_data  [DEPTH];
    logic                  stage_valid [DEPTH];
    logic                  stage_fresh [DEPTH];

    // A stalled load is dropped outright; upstream re-presents it later.
    always_comb begin
        load_ok  = bus.load_en & ~bus.stall;
        hold_d   = hold_q;
        loaded_d = loaded_q;
        if (load_ok) begin
            hold_d   = operand_merge #(DATA_WIDTH)::byte_merge(hold_q, bus.data_in, bus.load_be);
            loaded_d = loaded_q | (|bus.load_be);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q   <= RESET_VAL;
            loaded_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            loaded_q <= loaded_d;
        end
    end

    assign stage_en = ~bus.stall;

    // Stage 0 samples hold_d so an idle line recirculates the architectural value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            operand_pipe_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .RESET_VAL  (RESET_VAL)
            ) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .en        (stage_en),
                .clr       (bus.flush),
                .data_in   (hold_d),
                .valid_in  (loaded_d),
                .fresh_in  (bus.load_en),
                .data_out  (stage_data[i]),
                .valid_out (stage_valid[i]),
                .fresh_out (stage_fresh[i])
            );
        end else begin : g_tail
            operand_pipe_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .RESET_VAL  (RESET_VAL)
            ) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .en        (stage_en),
                .clr       (bus.flush),
                .data_in   (stage_data[i-1]),
                .valid_in  (stage_valid[i-1]),
                .fresh_in  (stage_fresh[i-1]),
                .data_out  (stage_data[i]),
                .valid_out (stage_valid[i]),
                .fresh_out (stage_fresh[i])
            );
        end
    end

    assign bus.hold_out  = hold_q;
    assign bus.data_out  = stage_data[DEPTH-1];
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out_fresh = stage_fresh[DEPTH-1];

endmodule
